// File: rtl/temp_fmt_pkg.sv
// Shared types and constants for the temperature-to-ASCII formatter.
// The same state encoding and character set are used by the top and its converter.
package temp_fmt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV_INT,
        CONV_FRAC,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE
    } fmt_state_t;

    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int FRAC_SCALE = 625;
    localparam int BIN_W      = 14;
    localparam int BCD_W      = 20;

    // sign + 3 integer digits + '.' + 4 fraction digits, optionally CR LF
    function automatic int frame_len(input bit add_crlf);
        return add_crlf ? 11 : 9;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: 14-bit binary to five BCD digits.
// One bit is processed per cycle; done pulses 15 cycles after an accepted start.
module bin_to_bcd
    import temp_fmt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    logic [BIN_W-1:0] shift_reg;
    logic [BCD_W-1:0] acc_reg;
    logic [BCD_W-1:0] acc_adj;
    logic [3:0]       cnt_reg;
    logic             running_reg;

    // Add-3 correction on every digit that would overflow past 9 after the shift
    genvar gi;
    generate
        for (gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
            assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                        acc_reg[4*gi +: 4] + 4'd3 :
                                        acc_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_reg   <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
            bcd         <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (running_reg) begin
                if (cnt_reg != 4'd0) begin
                    acc_reg   <= (acc_adj << 1) | BCD_W'(shift_reg[BIN_W-1]);
                    shift_reg <= shift_reg << 1;
                    cnt_reg   <= cnt_reg - 4'd1;
                end else begin
                    bcd         <= acc_reg;
                    done        <= 1'b1;
                    running_reg <= 1'b0;
                end
            end else if (start) begin
                shift_reg   <= bin;
                acc_reg     <= '0;
                cnt_reg     <= 4'(BIN_W);
                running_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/temp_ascii_formatter.sv
// Converts one ADT7420 13-bit temperature sample into "+ddd.dddd[CR LF]" and
// streams it byte by byte into uart_tx using its ready/data_valid handshake.
module temp_ascii_formatter
    import temp_fmt_pkg::*;
#(
    parameter int NUM_BITS = 8,
    parameter bit ADD_CRLF = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         temp_raw,
    input  logic                temp_valid,
    input  logic                tx_ready,
    output logic [NUM_BITS-1:0] tx_byte,
    output logic                tx_valid,
    output logic                busy,
    output logic                dropped
);

    localparam int         FRAME_LEN = frame_len(ADD_CRLF);
    localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

    fmt_state_t  state_reg;
    logic [3:0]  idx_reg;
    logic        sign_reg;
    logic [13:0] frac_val_reg;
    logic [11:0] int_bcd_reg;
    logic [15:0] frac_bcd_reg;

    logic [13:0] raw_ext;
    logic [13:0] mag;
    logic [13:0] frac_val;
    logic [13:0] conv_bin;
    logic        conv_start;
    logic        conv_done;
    logic [19:0] conv_bcd;
    logic [7:0]  int_chr  [3];
    logic [7:0]  frac_chr [4];
    logic [7:0]  frame_byte;
    logic [6:0]  unused_bits;

    assign raw_ext  = {temp_raw[15], temp_raw[15:3]};
    assign mag      = temp_raw[15] ? (~raw_ext + 14'd1) : raw_ext;
    assign frac_val = 14'(mag[3:0]) * 14'(FRAC_SCALE);

    // Integer conversion starts on the capture edge itself and the fraction
    // conversion on the integer done edge, keeping first-byte latency at 33 cycles.
    assign conv_start = ((state_reg == IDLE) && temp_valid) ||
                        ((state_reg == CONV_INT) && conv_done);
    assign conv_bin   = (state_reg == IDLE) ? {4'd0, mag[13:4]} : frac_val_reg;

    assign unused_bits = {conv_bcd[19:16], temp_raw[2:0]};

    bin_to_bcd u_bin_to_bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (conv_bin),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_int_chr
            assign int_chr[gi] = ASCII_ZERO + {4'd0, int_bcd_reg[4*(2-gi) +: 4]};
        end
        for (gi = 0; gi < 4; gi++) begin : g_frac_chr
            assign frac_chr[gi] = ASCII_ZERO + {4'd0, frac_bcd_reg[4*(3-gi) +: 4]};
        end
    endgenerate

    always_comb begin
        frame_byte = 8'h00;
        case (idx_reg)
            4'd0:    frame_byte = sign_reg ? ASCII_MINUS : ASCII_PLUS;
            4'd1:    frame_byte = int_chr[0];
            4'd2:    frame_byte = int_chr[1];
            4'd3:    frame_byte = int_chr[2];
            4'd4:    frame_byte = ASCII_DOT;
            4'd5:    frame_byte = frac_chr[0];
            4'd6:    frame_byte = frac_chr[1];
            4'd7:    frame_byte = frac_chr[2];
            4'd8:    frame_byte = frac_chr[3];
            4'd9:    frame_byte = ASCII_CR;
            4'd10:   frame_byte = ASCII_LF;
            default: frame_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            sign_reg     <= 1'b0;
            frac_val_reg <= '0;
            int_bcd_reg  <= '0;
            frac_bcd_reg <= '0;
            tx_byte      <= '0;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            dropped      <= 1'b0;
        end else begin
            dropped  <= temp_valid && (state_reg != IDLE);
            tx_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (temp_valid) begin
                        sign_reg     <= temp_raw[15];
                        frac_val_reg <= frac_val;
                        busy         <= 1'b1;
                        state_reg    <= CONV_INT;
                    end
                end
                CONV_INT: begin
                    if (conv_done) begin
                        int_bcd_reg <= conv_bcd[11:0];
                        state_reg   <= CONV_FRAC;
                    end
                end
                CONV_FRAC: begin
                    if (conv_done) begin
                        frac_bcd_reg <= conv_bcd[15:0];
                        idx_reg      <= '0;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_byte   <= NUM_BITS'(frame_byte);
                        tx_valid  <= 1'b1;
                        state_reg <= WAIT_BUSY;
                    end
                end
                // uart_tx holds ready for one cycle after accepting; wait for the
                // falling then rising edge so a byte is never issued twice.
                WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state_reg <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (tx_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 4'd1;
                            state_reg <= SEND;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_ascii_formatter.sv
// Scoreboard bench: expected frame bytes are queued when a sample is sent and
// compared as the DUT issues them into a behavioural uart_tx ready model.
module tb_temp_ascii_formatter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] temp_raw = 16'h0000;
    logic        temp_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        busy;
    logic        dropped;

    int          n_checks = 0;
    int          n_fail = 0;
    int          rx_count = 0;
    int          ucnt = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  exp_q [$];

    temp_ascii_formatter #(.NUM_BITS(8), .ADD_CRLF(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .temp_raw   (temp_raw),
        .temp_valid (temp_valid),
        .tx_ready   (tx_ready),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal reference: 13-bit two's complement in 1/16 degC units
    task automatic push_frame(input logic [15:0] raw);
        int t, m, ip, fp;
        t = int'(raw[15:3]);
        if (raw[15]) t = t - 8192;
        m  = (t < 0) ? -t : t;
        ip = m / 16;
        fp = (m % 16) * 625;
        exp_q.push_back((t < 0) ? 8'h2D : 8'h2B);
        exp_q.push_back(8'(48 + (ip / 100) % 10));
        exp_q.push_back(8'(48 + (ip / 10) % 10));
        exp_q.push_back(8'(48 + ip % 10));
        exp_q.push_back(8'h2E);
        exp_q.push_back(8'(48 + (fp / 1000) % 10));
        exp_q.push_back(8'(48 + (fp / 100) % 10));
        exp_q.push_back(8'(48 + (fp / 10) % 10));
        exp_q.push_back(8'(48 + fp % 10));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // uart_tx model: ready stays high one cycle after accepting, then low 20 cycles
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (tx_valid) begin
            check("tx_valid_gap", 32'(prev_valid), 0);
            check("issue_while_busy", 32'(ucnt > 0 && ucnt < 21), 0);
            if (exp_q.size() == 0) begin
                check("spurious_tx", 32'(exp_q.size()), 1);
            end else begin
                exp_b = exp_q.pop_front();
                check($sformatf("byte%0d", rx_count), 32'(tx_byte), 32'(exp_b));
            end
            rx_count++;
            ucnt = 21;
        end else if (ucnt > 0) begin
            ucnt--;
        end
        tx_ready   = (ucnt == 0) || (ucnt == 21);
        prev_valid = tx_valid;
    end

    task automatic send_temp(input logic [15:0] raw, input bit expect_drop);
        @(negedge clk);
        temp_raw   = raw;
        temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        check($sformatf("dropped_%04h", raw), 32'(dropped), 32'(expect_drop));
        check($sformatf("busy_%04h", raw), 32'(busy), 1);
        if (!expect_drop) push_frame(raw);
        $display("sample raw=0x%04h %s", raw, expect_drop ? "expected dropped" : "accepted");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        check("busy_end", 32'(busy), 0);
        check("bytes_left", 32'(exp_q.size()), 0);
    endtask

    logic [15:0] samples [7] = '{16'h0C80, 16'hE480, 16'hFFF8, 16'h0000,
                                 16'h4B08, 16'h8000, 16'h0C87};

    initial begin
        int k;
        int base;

        repeat (3) @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dropped", 32'(dropped), 0);
        reset = 1'b1;

        // First sample also measures latency to first byte
        send_temp(samples[0], 1'b0);
        k = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_valid) break;
            k++;
        end
        check("first_latency_le33", 32'(k <= 33), 1);
        wait_idle();

        for (int s = 1; s < 7; s++) begin
            send_temp(samples[s], 1'b0);
            wait_idle();
        end

        // Sample arriving mid-frame is discarded
        send_temp(16'h4B08, 1'b0);
        repeat (60) @(negedge clk);
        send_temp(16'h8000, 1'b1);
        @(negedge clk);
        check("dropped_one_cycle", 32'(dropped), 0);
        wait_idle();

        // Reset during the fourth byte aborts the frame
        base = rx_count;
        send_temp(16'h4B08, 1'b0);
        for (int i = 0; i < 500; i++) begin
            if (rx_count >= base + 4) break;
            @(negedge clk);
        end
        check("reached_byte4", 32'(rx_count >= base + 4), 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_valid", 32'(tx_valid), 0);
        check("mid_rst_tx_byte", 32'(tx_byte), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_dropped", 32'(dropped), 0);
        exp_q.delete();
        reset = 1'b1;
        send_temp(16'h0C80, 1'b0);
        wait_idle();

        repeat (30) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/temp_ascii_formatter.md
# temp_ascii_formatter

Upstream feeder for the UART transmitter: it accepts one raw 16-bit ADT7420 temperature word (13-bit mode) per `temp_valid` pulse and converts it to fixed-point decimal ASCII. It then streams that text byte by byte into `uart_tx` through its `tx_byte`/`data_valid`/`ready` handshake. It sits between the I2C read controller and `uart_tx`.

## Interface
- `NUM_BITS`, 8: width of each transmitted byte; must match `uart_tx`.
- `ADD_CRLF`, 1: when 1, append 0x0D 0x0A to every frame.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `temp_raw`  in  16  ADT7420 temperature register; bits [15:3] are a two's-complement value in 0.0625 °C units; bits [2:0] are ignored.
- `temp_valid`  in  1  one-cycle strobe; `temp_raw` is valid in that cycle.
- `tx_ready`  in  1  `ready` output of `uart_tx`.
- `tx_byte`  out  NUM_BITS  ASCII byte to `uart_tx`.
- `tx_valid`  out  1  one-cycle strobe to `uart_tx` `data_valid`.
- `busy`  out  1  high from sample capture until the last byte of the frame has been transmitted.
- `dropped`  out  1  one-cycle pulse when `temp_valid` arrives while `busy`.

## Operation
- Frame format: sign, 3 integer digits, '.', 4 fraction digits, then CR LF if `ADD_CRLF`. That is 11 bytes, or 9 without CR LF.
- Sign rules: '+' (0x2B) for values ≥ 0, including zero; '-' (0x2D) for negative values.
- Capture in IDLE on `temp_valid`:
  - `v = temp_raw[15:3]` sign-extended to 14 bits.
  - `mag = sign ? -v : v`. The maximum is 4096, for -256 °C.
  - `int_part = mag[13:4]` (0..256).
  - `frac_val = mag[3:0] * 625` (0..9375, 14 bits, exact).
- Conversions use one shared sequential binary-to-BCD converter: first `int_part` (low 3 digits used), then `frac_val` (low 4 digits used). Digit d is emitted as 0x30+d.
- State machine:
  - IDLE: on `temp_valid`, capture and go to CONV_INT.
  - CONV_INT: start the converter. On `done`, latch the digits and go to CONV_FRAC.
  - CONV_FRAC: start the converter. On `done`, latch the digits, set the byte index to 0, and go to SEND.
  - SEND: if `tx_ready`=1, drive `tx_byte`=frame[idx], set `tx_valid`<=1, and go to WAIT_BUSY.
  - WAIT_BUSY: `tx_valid`<=0. Wait for `tx_ready`=0, then go to WAIT_IDLE.
  - WAIT_IDLE: wait for `tx_ready`=1. If idx is the last byte, go to IDLE; otherwise idx++ and go to SEND.
- Why the extra waits: `uart_tx` keeps `ready` high for one cycle after accepting a byte. Edge-tracking through WAIT_BUSY then WAIT_IDLE therefore prevents double-issue.
- `temp_valid` while `busy`: the sample is discarded, `dropped` pulses for 1 cycle, and the current frame is unaffected.
- `temp_valid` in the same cycle the FSM returns to IDLE: treated as busy and dropped.

## Timing
- Reset values (`reset`=0 at a clock edge): state IDLE, `tx_byte`=0, `tx_valid`=0, `busy`=0, `dropped`=0, idx=0, converter cleared.
- Reset mid-frame aborts immediately; the frame is never resumed. A byte already accepted by `uart_tx` completes on the line.
- `busy` rises the cycle after the captured `temp_valid` and falls the cycle after the final WAIT_IDLE exit.
- Converter latency: `done` pulses exactly 15 cycles after `start` (14 shift/add-3 cycles plus 1).
- First `tx_valid` occurs ≤ 33 cycles after `temp_valid`, given `tx_ready`=1.
- `tx_valid` is registered and never high on two consecutive cycles. `tx_byte` is stable from the `tx_valid` cycle until the next SEND.

## Structure
- Package `temp_fmt_pkg` holds:
  - the state enum (IDLE, CONV_INT, CONV_FRAC, SEND, WAIT_BUSY, WAIT_IDLE);
  - ASCII constants `ASCII_PLUS`, `ASCII_MINUS`, `ASCII_DOT`, `ASCII_CR`, `ASCII_LF`, `ASCII_ZERO`;
  - `FRAC_SCALE`=625;
  - function `frame_len(add_crlf)`.
- Sub-module `bin_to_bcd`:
  - ports: `clk`, `reset`, `start`, `bin[13:0]`, `bcd[19:0]`, `done`;
  - sequential double-dabble, one bit per cycle, same reset convention as this block.

## Test plan
- `temp_raw`=0x0C80 (25.0 °C) -> bytes "+025.0000" 0x0D 0x0A on `tx_byte`, 11 `tx_valid` pulses, `busy` low afterwards.
- 0xE480 (-55 °C) -> "-055.0000\r\n". 0xFFF8 (-0.0625) -> "-000.0625\r\n". 0x0000 -> "+000.0000\r\n".
- 0x4B08 -> "+150.0625\r\n". 0x8000 -> "-256.0000\r\n". 0x0C87 -> identical to 0x0C80, since low bits are ignored.
- Second `temp_valid` mid-frame with a different value -> `dropped` pulses once, and the first frame completes unaltered.
- Bench holds `tx_ready` high 1 cycle after each `tx_valid`, then low for 20 cycles -> exactly one `tx_valid` per byte, with no duplicates.
- `reset` low during byte 4 -> all outputs at reset values next cycle; a new `temp_valid` produces a complete fresh frame.
